drbg_sequencer: RTL
===================

# drbg_sequencer

Command sequencer for the CTR-DRBG wrapper. It drives the DRBG `instantiate`, `reseed` and `generate` commands and the block count, which control otherwise leaves unsequenced. After reset and once health is good, it instantiates the DRBG. It then issues generate bursts whenever the output buffer can accept random blocks, and forces a reseed before the block budget since the last seed would exceed the reseed interval.

## Interface
Parameters:
- BLOCKS_PER_GEN, 16: 128-bit blocks requested per generate command; range 1..RESEED_INTERVAL.
- RESEED_INTERVAL, 511: maximum blocks produced between seeds (instantiate or reseed).
- CMD_TIMEOUT, 4095: maximum cycles spent in any wait state before fault.

Ports:
- clk  in  1  system clock (muxed ic_clk/debug_clk from control).
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  sequencing allowed; control drives it low in debug mode.
- health_ok  in  1  AND of temperature-sense-good and entropy-good flags.
- buf_ready_i  in  1  output buffer can accept DRBG random blocks.
- drbg_busy_i  in  1  DRBG wrapper not idle.
- drbg_random_valid_i  in  1  one pulse per 128-bit block emitted by the DRBG.
- drbg_instantiate_o  out  1  one-cycle instantiate command.
- drbg_reseed_o  out  1  one-cycle reseed command.
- drbg_generate_o  out  1  one-cycle generate command.
- num_blocks_o  out  16  block count for generate; valid while drbg_generate_o is high.
- blocks_since_seed_o  out  16  blocks emitted since last instantiate or reseed.
- state_o  out  3  current state encoding, for the SPI status register.
- fault_o  out  1  sticky timeout fault.

## Operation
States and encodings: IDLE=0, INST_WAIT=1, READY=2, GEN_WAIT=3, RESEED_WAIT=4, FAULT=5.

- IDLE:
  - If enable && health_ok: pulse drbg_instantiate_o, clear blocks_since_seed_o, go to INST_WAIT.
  - Otherwise stay in IDLE.
- READY (priority order):
  1. If !enable || !health_ok: go to IDLE with no pulse. Re-entry later always re-instantiates.
  2. Else if blocks_since_seed_o + BLOCKS_PER_GEN > RESEED_INTERVAL: pulse drbg_reseed_o, go to RESEED_WAIT.
  3. Else if buf_ready_i: pulse drbg_generate_o with num_blocks_o=BLOCKS_PER_GEN, go to GEN_WAIT.
  4. Else stay in READY.
- Wait states (INST_WAIT, GEN_WAIT, RESEED_WAIT):
  - Ignore drbg_busy_i in the first wait cycle, so the wrapper has one cycle to raise busy.
  - From the second cycle on, drbg_busy_i==0 ends the wait.
  - INST_WAIT and GEN_WAIT then go to READY. RESEED_WAIT clears blocks_since_seed_o and goes to READY.
- Block counting:
  - blocks_since_seed_o increments on every drbg_random_valid_i in any state except IDLE and FAULT.
  - It saturates at 16'hFFFF.
  - A clear and an increment in the same cycle resolve to 0.
- Dropping health or enable during a wait state does not abort the command. The sequencer finishes the wait, then READY routes to IDLE.
- Timeout:
  - A 16-bit wait counter resets on entry to each wait state.
  - If it reaches CMD_TIMEOUT while still waiting, go to FAULT and set fault_o.
- FAULT: absorbing until rst_n; no command pulses.
- At most one command pulse is high in any cycle. A pulse is never issued while drbg_busy_i is high.

## Timing
- Reset values: all command pulses 0, num_blocks_o=0, blocks_since_seed_o=0, state_o=0 (IDLE), fault_o=0, wait counter 0.
- All outputs are registered.
- A command pulse is high for exactly the first cycle in which state_o shows the matching wait state.
- Decision latency: condition true in cycle N in IDLE/READY → pulse and new state visible in cycle N+1.
- Command throughput: minimum 3 cycles from one pulse to the next (pulse cycle, busy-low cycle, READY cycle).
- num_blocks_o holds BLOCKS_PER_GEN during the generate pulse and is 0 otherwise.
- Reset mid-operation: asserting rst_n low returns all outputs to reset values immediately; any in-flight command is abandoned.

## Test plan
- Reset, then enable=1, health_ok=1, busy held high 5 cycles after the pulse → drbg_instantiate_o high 1 cycle, state_o=1 for 6 cycles, then state_o=2.
- BLOCKS_PER_GEN=16, RESEED_INTERVAL=64, buf_ready_i=1, DRBG model emits 16 valids per generate → four generate pulses with num_blocks_o=16, blocks_since_seed_o=64, then drbg_reseed_o pulse, counter back to 0, generates resume.
- In READY with buf_ready_i=0 for 100 cycles → no pulses, state_o=2. Raise buf_ready_i → generate pulse 1 cycle later.
- health_ok drops mid-GEN_WAIT → wait completes on busy low, READY then IDLE with no pulse. health_ok returns → new instantiate pulse, counter 0.
- CMD_TIMEOUT=10, busy stuck high after generate → state_o=5 and fault_o=1 on the 10th wait cycle. Both stay latched, no pulses, until rst_n low clears them.
- rst_n asserted during RESEED_WAIT → all outputs 0 asynchronously. After release with enable=1 → instantiate pulse.

Source files
------------

// File: rtl/drbg_sequencer.sv
// CTR-DRBG command sequencer: instantiate, generate bursts while the buffer accepts, forced reseed before budget overrun.
// All outputs registered; decisions in IDLE/READY appear one cycle later; buf_ready_i/drbg_busy_i stall issue, wait states time out to FAULT.
module drbg_sequencer #(
    parameter int unsigned BLOCKS_PER_GEN  = 16,
    parameter int unsigned RESEED_INTERVAL = 511,
    parameter int unsigned CMD_TIMEOUT     = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        health_ok,
    input  logic        buf_ready_i,
    input  logic        drbg_busy_i,
    input  logic        drbg_random_valid_i,
    output logic        drbg_instantiate_o,
    output logic        drbg_reseed_o,
    output logic        drbg_generate_o,
    output logic [15:0] num_blocks_o,
    output logic [15:0] blocks_since_seed_o,
    output logic [2:0]  state_o,
    output logic        fault_o
);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_INST_WAIT   = 3'd1,
        ST_READY       = 3'd2,
        ST_GEN_WAIT    = 3'd3,
        ST_RESEED_WAIT = 3'd4,
        ST_FAULT       = 3'd5
    } state_e;

    localparam logic [15:0] BLK_GEN    = 16'(BLOCKS_PER_GEN);
    localparam logic [16:0] BLK_GEN_X  = 17'(BLOCKS_PER_GEN);
    localparam logic [16:0] RESEED_LIM = 17'(RESEED_INTERVAL);
    localparam logic [15:0] TMO        = 16'(CMD_TIMEOUT);

    state_e      state_q, state_d;
    logic        inst_q, inst_d;
    logic        reseed_q, reseed_d;
    logic        gen_q, gen_d;
    logic [15:0] nblk_q, nblk_d;
    logic [15:0] bss_q, bss_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        fault_q, fault_d;

    logic        seed_clr;
    logic        wait_done;
    logic        budget_hit;
    logic        count_en;
    logic [15:0] wcnt_inc;

    // busy is only trusted from the second wait cycle on
    assign wait_done  = (wcnt_q != 16'd0) && !drbg_busy_i;
    assign wcnt_inc   = wcnt_q + 16'd1;
    assign budget_hit = ({1'b0, bss_q} + BLK_GEN_X) > RESEED_LIM;

    always_comb begin
        state_d  = state_q;
        inst_d   = 1'b0;
        reseed_d = 1'b0;
        gen_d    = 1'b0;
        nblk_d   = 16'd0;
        wcnt_d   = wcnt_q;
        fault_d  = fault_q;
        seed_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && health_ok && !drbg_busy_i) begin
                    inst_d   = 1'b1;
                    seed_clr = 1'b1;
                    wcnt_d   = 16'd0;
                    state_d  = ST_INST_WAIT;
                end
            end
            ST_READY: begin
                if (!enable || !health_ok) begin
                    state_d = ST_IDLE;
                end else if (!drbg_busy_i) begin
                    if (budget_hit) begin
                        reseed_d = 1'b1;
                        wcnt_d   = 16'd0;
                        state_d  = ST_RESEED_WAIT;
                    end else if (buf_ready_i) begin
                        gen_d   = 1'b1;
                        nblk_d  = BLK_GEN;
                        wcnt_d  = 16'd0;
                        state_d = ST_GEN_WAIT;
                    end
                end
            end
            ST_INST_WAIT, ST_GEN_WAIT, ST_RESEED_WAIT: begin
                // health/enable are not consulted here: an issued command always runs to completion
                if (wait_done) begin
                    seed_clr = (state_q == ST_RESEED_WAIT);
                    wcnt_d   = 16'd0;
                    state_d  = ST_READY;
                end else if (wcnt_inc >= TMO) begin
                    fault_d = 1'b1;
                    state_d = ST_FAULT;
                end else begin
                    wcnt_d = wcnt_inc;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign count_en = drbg_random_valid_i && (state_q != ST_IDLE) && (state_q != ST_FAULT);

    always_comb begin
        bss_d = bss_q;
        if (seed_clr) begin
            bss_d = 16'd0;
        end else if (count_en && (bss_q != 16'hFFFF)) begin
            bss_d = bss_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            inst_q   <= 1'b0;
            reseed_q <= 1'b0;
            gen_q    <= 1'b0;
            nblk_q   <= 16'd0;
            bss_q    <= 16'd0;
            wcnt_q   <= 16'd0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            inst_q   <= inst_d;
            reseed_q <= reseed_d;
            gen_q    <= gen_d;
            nblk_q   <= nblk_d;
            bss_q    <= bss_d;
            wcnt_q   <= wcnt_d;
            fault_q  <= fault_d;
        end
    end

    assign drbg_instantiate_o  = inst_q;
    assign drbg_reseed_o       = reseed_q;
    assign drbg_generate_o     = gen_q;
    assign num_blocks_o        = nblk_q;
    assign blocks_since_seed_o = bss_q;
    assign state_o             = state_q;
    assign fault_o             = fault_q;

endmodule
